// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready memory handshake
// and presents {instruction, PC+4} to IF/ID under a valid/accept handshake.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pcplus_out,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcplus_q, pcplus_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [31:0] target;
    logic [31:0] addr_plus4;

    assign target     = redirect_pc & ~32'h0000_0003;
    assign addr_plus4 = addr_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            inst_q   <= '0;
            pcplus_q <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            pcplus_q <= pcplus_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        pcplus_d = pcplus_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        case (state_q)
            S_IDLE, S_PRESENT: begin
                if (redirect_valid) begin
                    // Redirect wins over an accept in the same cycle: the presented word is squashed.
                    valid_d = 1'b0;
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (state_q == S_IDLE) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (pc_write) begin
                    if (inst_q == HALT_WORD) begin
                        valid_d  = 1'b0;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        valid_d = 1'b0;
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (imem_ready) begin
                        addr_d = target;
                    end else begin
                        // Request must stay on the old address until memory answers.
                        state_d = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    inst_d   = imem_rdata;
                    pcplus_d = addr_plus4;
                    pc_d     = addr_plus4;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = S_PRESENT;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    addr_d  = redirect_valid ? target : pc_q;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst_out   = inst_q;
    assign pcplus_out = pcplus_q;
    assign halted     = halted_q;

endmodule
